// File: rtl/gps_gen_pkg.sv
// Shared definitions for the GPS generator control path.
//   gps_state_e      : sequencer state encoding, also exported on state_out
//   GPS_SAT_W        : width of the satellite select field
//   *_DEF            : default timing / width parameters
//   cnt_w()          : counter width for a modulo-n counter (never below 1 bit)
package gps_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SEEK  = 3'd2,
    ST_ARMED = 3'd3,
    ST_RUN   = 3'd4
  } gps_state_e;

  localparam int unsigned GPS_SAT_W           = 5;
  localparam int unsigned CLK_DIV_DEF         = 4;
  localparam int unsigned CHIPS_PER_EPOCH_DEF = 1023;
  localparam int unsigned EPOCHS_PER_BIT_DEF  = 20;
  localparam int unsigned PHASE_W_DEF         = 16;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gps_tick_div.sv
// Strobe generator: counts 0..DIV-1 and raises tick_out for one cycle while
// the count sits at DIV-1. clr_in holds the count at 0 and suppresses the tick.
//   clk_in   : clock
//   rst_in   : synchronous active-high reset
//   clr_in   : synchronous clear (count to 0, no tick this cycle)
//   tick_out : combinational strobe, registered by the caller
module gps_tick_div
  import gps_gen_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  output logic tick_out
);

  localparam int unsigned W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr_in) begin
      div_d = '0;
    end else if (div_q == LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_out = !clr_in && (div_q == LAST);

endmodule

// File: rtl/gps_gen_seq.sv
// Sequencer / configuration controller for gps_gen_core.
// Flow: IDLE -(cfg accepted)-> CLR (1 cycle core reset) -> SEEK (C/A phase
// seek until core reports done) -> ARMED -(start)-> RUN (paced sample strobes,
// chip/epoch/nav-bit timing). stop_in returns any active state to IDLE.
//
// Config handshake: a config word transfers on a rising clk_in edge where
// cfg_valid_in=1 and cfg_ready_out=1 (and stop_in=0); cfg_ready_out is high
// only in IDLE, so offers in any other state are simply not taken.
//
// Ports:
//   clk_in, rst_in                       clock, synchronous active-high reset
//   cfg_valid_in/cfg_ready_out           config handshake
//   cfg_sat_in/cfg_phase_in/cfg_doppler_in  config payload
//   start_in, stop_in                    run control
//   msg_bit_in/msg_req_out               nav message bit request / data
//   core_*_out, core_phase_done_in       gps_gen_core control interface
//   epoch_out                            pulse on last chip of each code epoch
//   busy_out, state_out                  status / debug state
// All outputs are registered.
module gps_gen_seq
  import gps_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV         = CLK_DIV_DEF,
  parameter int unsigned CHIPS_PER_EPOCH = CHIPS_PER_EPOCH_DEF,
  parameter int unsigned EPOCHS_PER_BIT  = EPOCHS_PER_BIT_DEF,
  parameter int unsigned PHASE_W         = PHASE_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cfg_valid_in,
  output logic               cfg_ready_out,
  input  logic [4:0]         cfg_sat_in,
  input  logic [PHASE_W-1:0] cfg_phase_in,
  input  logic [7:0]         cfg_doppler_in,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic               msg_bit_in,
  output logic               msg_req_out,
  output logic               core_rst_n_out,
  output logic               core_ena_out,
  output logic               core_phase_start_out,
  output logic [4:0]         core_n_sat_out,
  output logic [PHASE_W-1:0] core_ca_phase_out,
  output logic [7:0]         core_doppler_out,
  output logic               core_msg_out,
  input  logic               core_phase_done_in,
  output logic               epoch_out,
  output logic               busy_out,
  output logic [2:0]         state_out
);

  localparam int unsigned CHIP_W = cnt_w(CHIPS_PER_EPOCH);
  localparam int unsigned EPB_W  = cnt_w(EPOCHS_PER_BIT);
  localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CHIPS_PER_EPOCH - 1);
  localparam logic [EPB_W-1:0]  EPB_LAST  = EPB_W'(EPOCHS_PER_BIT - 1);

  gps_state_e         state_q, state_d;
  logic               seek_first_q, seek_first_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               msg_req_q, msg_req_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               core_ena_q, core_ena_d;
  logic               phase_start_q, phase_start_d;
  logic [4:0]         n_sat_q, n_sat_d;
  logic [PHASE_W-1:0] ca_phase_q, ca_phase_d;
  logic [7:0]         doppler_q, doppler_d;
  logic               core_msg_q, core_msg_d;
  logic               epoch_q, epoch_d;
  logic               busy_q, busy_d;
  logic [CHIP_W-1:0]  chip_q, chip_d;
  logic [EPB_W-1:0]   epb_q, epb_d;

  logic div_clr;
  logic tick;

  // Divider only runs in RUN; a stop on the strobe cycle kills that strobe.
  assign div_clr = (state_q != ST_RUN) || stop_in;

  gps_tick_div #(
    .DIV(CLK_DIV)
  ) u_tick_div (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (div_clr),
    .tick_out(tick)
  );

  always_comb begin
    state_d       = state_q;
    seek_first_d  = 1'b0;
    msg_req_d     = 1'b0;
    core_rst_n_d  = 1'b1;
    core_ena_d    = 1'b0;
    phase_start_d = 1'b0;
    epoch_d       = 1'b0;
    n_sat_d       = n_sat_q;
    ca_phase_d    = ca_phase_q;
    doppler_d     = doppler_q;
    chip_d        = chip_q;
    epb_d         = epb_q;
    // The bit offered while msg_req_out is high becomes the current bit.
    core_msg_d    = msg_req_q ? msg_bit_in : core_msg_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_in && cfg_ready_q && !stop_in) begin
          n_sat_d      = cfg_sat_in;
          ca_phase_d   = cfg_phase_in;
          doppler_d    = cfg_doppler_in;
          core_rst_n_d = 1'b0;
          state_d      = ST_CLR;
        end
      end
      ST_CLR: begin
        phase_start_d = 1'b1;
        seek_first_d  = 1'b1;
        state_d       = ST_SEEK;
      end
      ST_SEEK: begin
        // Done from the core is not trusted on the first seek cycle: it may
        // still reflect the state before the CLR reset took effect.
        if (!seek_first_q && core_phase_done_in) begin
          state_d = ST_ARMED;
        end else begin
          phase_start_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (start_in) begin
          msg_req_d = 1'b1;
          chip_d    = '0;
          epb_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          core_ena_d = 1'b1;
          if (chip_q == CHIP_LAST) begin
            chip_d  = '0;
            epoch_d = 1'b1;
            if (epb_q == EPB_LAST) begin
              epb_d     = '0;
              msg_req_d = 1'b1;
            end else begin
              epb_d = epb_q + 1'b1;
            end
          end else begin
            chip_d = chip_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort has priority over every other request and silences all pulses.
    if (stop_in) begin
      state_d       = ST_IDLE;
      seek_first_d  = 1'b0;
      msg_req_d     = 1'b0;
      core_rst_n_d  = 1'b1;
      core_ena_d    = 1'b0;
      phase_start_d = 1'b0;
      epoch_d       = 1'b0;
    end

    cfg_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      seek_first_q  <= 1'b0;
      cfg_ready_q   <= 1'b1;
      msg_req_q     <= 1'b0;
      core_rst_n_q  <= 1'b1;
      core_ena_q    <= 1'b0;
      phase_start_q <= 1'b0;
      n_sat_q       <= '0;
      ca_phase_q    <= '0;
      doppler_q     <= '0;
      core_msg_q    <= 1'b0;
      epoch_q       <= 1'b0;
      busy_q        <= 1'b0;
      chip_q        <= '0;
      epb_q         <= '0;
    end else begin
      state_q       <= state_d;
      seek_first_q  <= seek_first_d;
      cfg_ready_q   <= cfg_ready_d;
      msg_req_q     <= msg_req_d;
      core_rst_n_q  <= core_rst_n_d;
      core_ena_q    <= core_ena_d;
      phase_start_q <= phase_start_d;
      n_sat_q       <= n_sat_d;
      ca_phase_q    <= ca_phase_d;
      doppler_q     <= doppler_d;
      core_msg_q    <= core_msg_d;
      epoch_q       <= epoch_d;
      busy_q        <= busy_d;
      chip_q        <= chip_d;
      epb_q         <= epb_d;
    end
  end

  assign cfg_ready_out        = cfg_ready_q;
  assign msg_req_out          = msg_req_q;
  assign core_rst_n_out       = core_rst_n_q;
  assign core_ena_out         = core_ena_q;
  assign core_phase_start_out = phase_start_q;
  assign core_n_sat_out       = n_sat_q;
  assign core_ca_phase_out    = ca_phase_q;
  assign core_doppler_out     = doppler_q;
  assign core_msg_out         = core_msg_q;
  assign epoch_out            = epoch_q;
  assign busy_out             = busy_q;
  assign state_out            = state_q;

endmodule

// File: tb/tb_gps_gen_seq.sv
// Bench for gps_gen_seq. Stimulus pushes time-stamped expected events
// (state changes, msg requests, epoch pulses, message bit changes) into
// exp_q; a negedge monitor pops and compares each event the DUT presents.
// Strobe pacing and control-output consistency are checked every cycle.
module tb_gps_gen_seq;

  localparam int D     = 3;     // CLK_DIV used here (non power of two)
  localparam int CHIPS = 1023;
  localparam int EPB   = 20;

  localparam logic [3:0] K_STATE  = 4'd1;
  localparam logic [3:0] K_MSGREQ = 4'd2;
  localparam logic [3:0] K_EPOCH  = 4'd3;
  localparam logic [3:0] K_MSG    = 4'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        cfg_valid = 1'b0, cfg_ready;
  logic [4:0]  cfg_sat = '0;
  logic [15:0] cfg_phase = '0;
  logic [7:0]  cfg_dop = '0;
  logic        start = 1'b0, stop = 1'b0, msg_bit = 1'b0;
  logic        msg_req, core_rst_n, core_ena, phase_start, core_msg, epoch, busy;
  logic [4:0]  n_sat;
  logic [15:0] ca_phase;
  logic [7:0]  doppler;
  logic        phase_done;
  logic [2:0]  state;

  gps_gen_seq #(
    .CLK_DIV(D), .CHIPS_PER_EPOCH(CHIPS), .EPOCHS_PER_BIT(EPB), .PHASE_W(16)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready),
    .cfg_sat_in(cfg_sat), .cfg_phase_in(cfg_phase), .cfg_doppler_in(cfg_dop),
    .start_in(start), .stop_in(stop),
    .msg_bit_in(msg_bit), .msg_req_out(msg_req),
    .core_rst_n_out(core_rst_n), .core_ena_out(core_ena),
    .core_phase_start_out(phase_start),
    .core_n_sat_out(n_sat), .core_ca_phase_out(ca_phase),
    .core_doppler_out(doppler), .core_msg_out(core_msg),
    .core_phase_done_in(phase_done),
    .epoch_out(epoch), .busy_out(busy), .state_out(state)
  );

  // ---------------- core phase-seek model ----------------
  // Counts seek cycles since the last core reset; done once count >= phase.
  int model_cnt = 0;
  int model_phase = 0;
  always @(posedge clk) begin
    if (!core_rst_n) model_cnt <= 0;
    else if (phase_start) model_cnt <= model_cnt + 1;
  end
  assign phase_done = phase_start && (model_cnt >= model_phase);

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [39:0] ev(input logic [3:0] k, input logic [3:0] v, input int c);
    return {k, v, c};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_pop(input logic [39:0] act);
    logic [39:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: actual=%0h required=none", act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL sb_event: actual=%0h required=%0h", act, e);
      end
    end
  endtask

  function automatic logic [39:0] all_outs();
    return {cfg_ready, msg_req, core_rst_n, core_ena, phase_start, n_sat,
            ca_phase, doppler, core_msg, epoch, busy, state};
  endfunction

  localparam logic [39:0] RESET_OUTS = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,
                                        16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0};

  // ---------------- monitor ----------------
  logic [2:0] prev_state = 3'd0;
  logic       prev_msg = 1'b0;
  int         next_strobe = 0;

  always @(negedge clk) begin
    logic run_entry;
    logic exp_ena;
    run_entry = (state == 3'd4) && (prev_state != 3'd4);
    if (state !== prev_state) begin
      sb_pop(ev(K_STATE, {1'b0, state}, cyc));
      prev_state = state;
    end
    if (msg_req) sb_pop(ev(K_MSGREQ, 4'd0, cyc));
    if (epoch)   sb_pop(ev(K_EPOCH, 4'd0, cyc));
    if (core_msg !== prev_msg) begin
      sb_pop(ev(K_MSG, {3'd0, core_msg}, cyc));
      prev_msg = core_msg;
    end
    if (state == 3'd4) begin
      if (run_entry) next_strobe = cyc + D;
      exp_ena = (cyc == next_strobe);
      check("core_ena_run", 64'(core_ena), 64'(exp_ena));
      if (exp_ena) next_strobe = next_strobe + D;
    end else begin
      check("core_ena_idle", 64'(core_ena), 64'd0);
    end
    check("ctl_consistency", 64'({phase_start, core_rst_n, busy, cfg_ready}),
          64'({state == 3'd2, state != 3'd1, state != 3'd0, state == 3'd0}));
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a config in IDLE and wait until ARMED is reached.
  task automatic cfg_to_armed(input logic [4:0] s, input logic [15:0] p,
                              input logic [7:0] d, input int seek_len);
    int n;
    n = cyc;
    model_phase = int'(p);
    cfg_valid = 1'b1; cfg_sat = s; cfg_phase = p; cfg_dop = d;
    exp_q.push_back(ev(K_STATE, 4'd1, n + 1));
    exp_q.push_back(ev(K_STATE, 4'd2, n + 2));
    exp_q.push_back(ev(K_STATE, 4'd3, n + 2 + seek_len));
    tick_n(1);
    cfg_valid = 1'b0;
    tick_n(seek_len + 2);
  endtask

  task automatic stop_pulse();
    exp_q.push_back(ev(K_STATE, 4'd0, cyc + 1));
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    tick_n(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r, s;
    tick_n(3);
    check("reset_outputs", 64'(all_outs()), 64'(RESET_OUTS));
    rst = 1'b0;
    tick_n(2);

    // phase 0: CLR 1 cycle, SEEK 2 cycles, then ARMED with latched config
    cfg_to_armed(5'd3, 16'd0, 8'd10, 2);
    check("cfg_latched_3_0_10", 64'({n_sat, ca_phase, doppler}), 64'({5'd3, 16'd0, 8'd10}));
    stop_pulse();

    // phase 5: seek held until the core model reports done (6 seek cycles)
    cfg_to_armed(5'd7, 16'd5, 8'hA5, 6);
    check("cfg_latched_7_5_a5", 64'({n_sat, ca_phase, doppler}), 64'({5'd7, 16'd5, 8'hA5}));
    // offer in ARMED is not taken
    cfg_valid = 1'b1; cfg_sat = 5'd1; cfg_phase = 16'd1; cfg_dop = 8'd1;
    tick_n(2);
    cfg_valid = 1'b0;
    check("cfg_ignored_armed", 64'({n_sat, ca_phase, doppler}), 64'({5'd7, 16'd5, 8'hA5}));
    stop_pulse();

    // stop during SEEK: back to IDLE next cycle, config retained
    n = cyc;
    model_phase = 5;
    cfg_valid = 1'b1; cfg_sat = 5'd9; cfg_phase = 16'd5; cfg_dop = 8'h33;
    exp_q.push_back(ev(K_STATE, 4'd1, n + 1));
    exp_q.push_back(ev(K_STATE, 4'd2, n + 2));
    exp_q.push_back(ev(K_STATE, 4'd0, n + 4));
    tick_n(1);
    cfg_valid = 1'b0;
    tick_n(2);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    tick_n(1);
    check("cfg_kept_after_stop", 64'({n_sat, ca_phase, doppler}), 64'({5'd9, 16'd5, 8'h33}));

    // full run: 20 epochs, message bits 1 then 0, stop on a strobe cycle
    cfg_to_armed(5'd3, 16'd0, 8'd10, 2);
    tick_n(2);
    r = cyc + 1;
    exp_q.push_back(ev(K_STATE, 4'd4, r));
    exp_q.push_back(ev(K_MSGREQ, 4'd0, r));
    exp_q.push_back(ev(K_MSG, 4'd1, r + 1));
    for (int j = 1; j < EPB; j++) exp_q.push_back(ev(K_EPOCH, 4'd0, r + j * CHIPS * D));
    exp_q.push_back(ev(K_MSGREQ, 4'd0, r + EPB * CHIPS * D));
    exp_q.push_back(ev(K_EPOCH, 4'd0, r + EPB * CHIPS * D));
    exp_q.push_back(ev(K_MSG, 4'd0, r + EPB * CHIPS * D + 1));
    s = r + (EPB * CHIPS + 5) * D;
    exp_q.push_back(ev(K_STATE, 4'd0, s));
    start = 1'b1; msg_bit = 1'b1;
    tick_n(1);
    start = 1'b0;
    tick_n(1);
    msg_bit = 1'b0;
    tick_n(100);
    cfg_valid = 1'b1; cfg_sat = 5'd31; cfg_phase = 16'hFFFF; cfg_dop = 8'hFF;
    tick_n(3);
    cfg_valid = 1'b0;
    check("cfg_ignored_run", 64'({n_sat, ca_phase, doppler, cfg_ready}),
          64'({5'd3, 16'd0, 8'd10, 1'b0}));
    tick_n(s - 1 - cyc);
    stop = 1'b1;
    tick_n(1);
    stop = 1'b0;
    check("no_strobe_on_stop", 64'({core_ena, state}), 64'({1'b0, 3'd0}));
    tick_n(2);

    // reset in the middle of RUN
    cfg_to_armed(5'd3, 16'd0, 8'd10, 2);
    r = cyc + 1;
    exp_q.push_back(ev(K_STATE, 4'd4, r));
    exp_q.push_back(ev(K_MSGREQ, 4'd0, r));
    exp_q.push_back(ev(K_MSG, 4'd1, r + 1));
    exp_q.push_back(ev(K_STATE, 4'd0, r + 51));
    exp_q.push_back(ev(K_MSG, 4'd0, r + 51));
    start = 1'b1; msg_bit = 1'b1;
    tick_n(1);
    start = 1'b0;
    tick_n(50);
    msg_bit = 1'b0;
    rst = 1'b1;
    tick_n(1);
    check("reset_mid_run", 64'(all_outs()), 64'(RESET_OUTS));
    rst = 1'b0;
    tick_n(3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
